// File: rtl/ice40_ram_ctrl_if.sv
// Request/response stream bundle between a bus master and ice40_ram_ctrl.
// The master drives requests and accepts responses; the controller is the slave.
interface ice40_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [15:0]           req_wdata;
    logic [15:0]           req_bmask;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [15:0]           rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_bmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_bmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ice40_ram_ctrl.sv
// Request-stream front end for an SB_RAM40_4K (256x16): drives the RAM strobes
// on accept and returns read data through a credit-limited response FIFO.
module ice40_ram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESETN,
    ice40_ram_ctrl_if.slave      bus,
    output logic [10:0]          RADDR,
    output logic                 RE,
    output logic                 RCLKE,
    output logic [10:0]          WADDR,
    output logic                 WE,
    output logic                 WCLKE,
    output logic [15:0]          MASK,
    output logic [15:0]          WDATA,
    input  logic [15:0]          RDATA
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1);
    endfunction

    logic                 r_rdy_en;
    logic                 r_rd_pend;
    logic [CW-1:0]        r_count;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [15:0]          r_fifo [RSP_DEPTH];

    logic [CW-1:0]        w_inflight;
    logic                 w_req_ready;
    logic                 w_acc;
    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_push;
    logic                 w_pop;
    logic [10:0]          w_addr_ext;

    // Credits count both queued data and the read whose data is still in the RAM.
    assign w_inflight  = r_count + {{(CW-1){1'b0}}, r_rd_pend};
    assign w_req_ready = r_rdy_en & (w_inflight < CW'(RSP_DEPTH));
    assign w_acc       = bus.req_valid & w_req_ready;
    assign w_rd_acc    = w_acc & ~bus.req_we;
    assign w_wr_acc    = w_acc & bus.req_we;
    assign w_push      = r_rd_pend;
    assign w_pop       = (r_count != {CW{1'b0}}) & bus.rsp_ready;
    assign w_addr_ext  = {{(11-ADDR_WIDTH){1'b0}}, bus.req_addr};

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_count != {CW{1'b0}});
    assign bus.rsp_rdata = r_fifo[r_rd_ptr];

    // RAM strobes follow the accepted request in the same cycle.
    always_comb begin
        RADDR = 11'd0;
        RE    = 1'b0;
        RCLKE = 1'b0;
        WADDR = 11'd0;
        WE    = 1'b0;
        WCLKE = 1'b0;
        MASK  = 16'hFFFF;
        WDATA = 16'h0000;
        if (w_wr_acc) begin
            WE    = 1'b1;
            WCLKE = 1'b1;
            WADDR = w_addr_ext;
            WDATA = bus.req_wdata;
            MASK  = ~bus.req_bmask;
        end else if (w_rd_acc) begin
            RE    = 1'b1;
            RCLKE = 1'b1;
            RADDR = w_addr_ext;
        end else begin
            RE    = 1'b0;
        end
    end

    // Ready enable, pending-read flag, FIFO count and pointers.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_rdy_en  <= 1'b0;
            r_rd_pend <= 1'b0;
            r_count   <= {CW{1'b0}};
            r_wr_ptr  <= {PW{1'b0}};
            r_rd_ptr  <= {PW{1'b0}};
        end else begin
            r_rdy_en  <= 1'b1;
            r_rd_pend <= w_rd_acc;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
        end
    end

    // Response storage; RDATA is captured the cycle after the read strobe.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_fifo[i] <= 16'h0000;
            end
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= RDATA;
        end
    end

    ice40_ram_ctrl_chk #(
        .CW        (CW),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_chk (
        .clk     (CLK),
        .rst_n   (ASYNCRESETN),
        .push    (w_push),
        .pop     (w_pop),
        .count   (r_count)
    );
endmodule

// Guards the credit scheme: the response FIFO can never be pushed while full.
module ice40_ram_ctrl_chk #(
    parameter int CW        = 2,
    parameter int RSP_DEPTH = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !pop) |-> (count < CW'(RSP_DEPTH)));

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(RSP_DEPTH));
endmodule

// File: tb/tb_ice40_ram_ctrl.sv
// Directed bench for ice40_ram_ctrl with a behavioural SB_RAM40_4K and a
// read-response scoreboard fed from a reference memory image of accepted writes.
module tb_ice40_ram_ctrl;
    logic        CLK;
    logic        ASYNCRESETN;
    logic [10:0] RADDR, WADDR;
    logic        RE, RCLKE, WE, WCLKE;
    logic [15:0] MASK, WDATA, RDATA;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] ram     [256];
    logic [15:0] exp_mem [256];
    logic [15:0] sb [$];

    ice40_ram_ctrl_if #(.ADDR_WIDTH(8)) bus ();

    ice40_ram_ctrl #(
        .ADDR_WIDTH (8),
        .RSP_DEPTH  (3)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .bus         (bus),
        .RADDR       (RADDR),
        .RE          (RE),
        .RCLKE       (RCLKE),
        .WADDR       (WADDR),
        .WE          (WE),
        .WCLKE       (WCLKE),
        .MASK        (MASK),
        .WDATA       (WDATA),
        .RDATA       (RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural RAM: MASK bit 1 protects that bit; read data one cycle after RE.
    always @(posedge CLK) begin
        if (WE && WCLKE) ram[WADDR[7:0]] <= (ram[WADDR[7:0]] & MASK) | (WDATA & ~MASK);
        if (RE && RCLKE) RDATA <= ram[RADDR[7:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard push: accepted writes update the expected image, reads queue a result.
    always @(posedge CLK) begin
        if (ASYNCRESETN && bus.req_valid && bus.req_ready) begin
            if (bus.req_we)
                exp_mem[bus.req_addr] = (exp_mem[bus.req_addr] & ~bus.req_bmask)
                                      | (bus.req_wdata & bus.req_bmask);
            else
                sb.push_back(exp_mem[bus.req_addr]);
        end
    end

    // Scoreboard pop on every response handshake.
    always @(negedge CLK) begin
        if (ASYNCRESETN && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) check("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
            else                check("rsp_data", {16'd0, bus.rsp_rdata}, {16'd0, sb.pop_front()});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 16'h0000;
        bus.req_bmask = 16'h0000;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [15:0] m);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_bmask = m;
        @(negedge CLK);
        check("wr_ready", {31'd0, bus.req_ready}, 32'd1);
        check("wr_we",    {30'd0, WE, WCLKE}, 32'd3);
        check("wr_re",    {30'd0, RE, RCLKE}, 32'd0);
        check("wr_waddr", {21'd0, WADDR}, {24'd0, a});
        check("wr_wdata", {16'd0, WDATA}, {16'd0, d});
        check("wr_mask",  {16'd0, MASK}, {16'd0, ~m});
        step();
        idle();
    endtask

    task automatic do_read(input logic [7:0] a);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        @(negedge CLK);
        check("rd_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rd_re",    {30'd0, RE, RCLKE}, 32'd3);
        check("rd_we",    {30'd0, WE, WCLKE}, 32'd0);
        check("rd_raddr", {21'd0, RADDR}, {24'd0, a});
        check("rd_mask",  {16'd0, MASK}, 32'h0000FFFF);
        step();
        idle();
    endtask

    task automatic send_read_wait(input logic [7:0] a);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = a;
            @(negedge CLK);
            got = bus.req_ready;
            step();
        end
        idle();
        check("rd_accept", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        step();
        check("drain", sb.size(), 32'd0);
        @(negedge CLK);
        check("drain_valid", {31'd0, bus.rsp_valid}, 32'd0);
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd0);
        check({tag, "_rvalid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rdata"}, {16'd0, bus.rsp_rdata}, 32'd0);
        check({tag, "_strobes"}, {28'd0, RE, WE, RCLKE, WCLKE}, 32'd0);
        check({tag, "_addr"}, {10'd0, RADDR, WADDR}, 32'd0);
        check({tag, "_wdata"}, {16'd0, WDATA}, 32'd0);
        check({tag, "_mask"}, {16'd0, MASK}, 32'h0000FFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish by 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] n_acc;
        // Reset with a write request already presented: nothing may reach the RAM.
        ASYNCRESETN   = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 8'h33;
        bus.req_wdata = 16'h1234;
        bus.req_bmask = 16'hFFFF;
        #3;
        check_reset_outputs("rst0");
        #9;
        ASYNCRESETN = 1'b1;
        idle();
        @(negedge CLK);
        check("rst0_ready_after", {31'd0, bus.req_ready}, 32'd1);
        step();

        // Write then read the same address on the next cycle.
        do_write(8'h05, 16'hA5A5, 16'hFFFF);
        do_read(8'h05);
        @(negedge CLK);
        check("lat_n1_valid", {31'd0, bus.rsp_valid}, 32'd0);
        step();
        @(negedge CLK);
        check("lat_n2_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("lat_n2_data", {16'd0, bus.rsp_rdata}, 32'h0000A5A5);
        check("ram_05", {16'd0, ram[5]}, 32'h0000A5A5);
        step();
        wait_drain();

        // Bit-masked write over a cleared word.
        do_write(8'h10, 16'h0000, 16'hFFFF);
        do_write(8'h10, 16'hFFFF, 16'h00FF);
        check("ram_10", {16'd0, ram[8'h10]}, 32'h000000FF);
        do_read(8'h10);
        wait_drain();

        // Streaming reads with rsp_ready held high.
        for (int i = 0; i < 8; i++) do_write(8'(i), 16'h0100 + 16'(i), 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b0;
                bus.req_addr  = 8'(i);
            end else begin
                idle();
            end
            @(negedge CLK);
            if (i < 8)  check("stream_ready", {31'd0, bus.req_ready}, 32'd1);
            if (i >= 2) check("stream_valid", {31'd0, bus.rsp_valid}, 32'd1);
            step();
        end
        wait_drain();

        // Back-pressure: only three reads fit while responses are held.
        for (int i = 0; i < 5; i++) do_write(8'h20 + 8'(i), 16'h0200 + 16'(i), 16'hFFFF);
        bus.rsp_ready = 1'b0;
        n_acc = 3'd0;
        for (int c = 0; c < 7; c++) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = 8'h20 + 8'(n_acc);
            @(negedge CLK);
            check("bp_ready", {31'd0, bus.req_ready}, (c < 3) ? 32'd1 : 32'd0);
            if (c >= 3) begin
                check("bp_hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
                check("bp_hold_data", {16'd0, bus.rsp_rdata}, 32'h00000200);
            end
            if (bus.req_ready) n_acc = n_acc + 3'd1;
            step();
        end
        idle();
        check("bp_accepted", {29'd0, n_acc}, 32'd3);
        bus.rsp_ready = 1'b1;
        send_read_wait(8'h23);
        send_read_wait(8'h24);
        wait_drain();

        // Reset the cycle after a read accept: the in-flight data is dropped.
        do_read(8'h05);
        ASYNCRESETN = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("rst1");
        step();
        step();
        ASYNCRESETN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("rst1_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            check("rst1_ready", {31'd0, bus.req_ready}, (i > 0) ? 32'd1 : 32'd0);
            step();
        end
        do_read(8'h10);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
